// File: rtl/hazard_stall_unit.sv
// ---------------------------------------------------------------------------
// hazard_stall_unit
//
// Pipeline control for the hazards that operand forwarding cannot resolve:
//   - load-use between the load in EX and a consumer in ID (1-cycle stall),
//   - a multi-cycle divider occupying EX (DIV_LATENCY-1 stall cycles and
//     then one release cycle),
//   - a taken branch or jump in EX (flush IF/ID and bubble ID/EX).
//
// Parameters:
//   DIV_LATENCY  cycles the divider occupies EX, including the release
//                cycle (1..64). A value of 1 disables divide stalls.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   MemRead_IDEX      EX instruction is a load
//   rd_IDEX           EX destination register
//   rs1/rs2_IFID      ID source registers
//   uses_rs1/2_IFID   ID instruction really reads rs1/rs2
//   div_start_IDEX    EX instruction is a divide/remainder
//   branch_taken_EX   branch or jump in EX resolved as taken
//   stall_if/id/ex    hold the PC / IF/ID / ID/EX
//   bubble_ex/mem     load a NOP into ID/EX / EX/MEM
//   flush_id          load a NOP into IF/ID
//   div_busy          the divider is holding EX this cycle
//
// Optional feature, macro HAZARD_PERF_EN:
//   perf_load_stalls, perf_div_stalls, perf_flushes: 32-bit saturating
//   event counters (load-use stall cycles, divide stall cycles, flushes).
//
// All outputs are combinational from state, cnt and the current inputs,
// and are forced to 0 while rst is high.
// ---------------------------------------------------------------------------
module hazard_stall_unit #(
    parameter int DIV_LATENCY = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       MemRead_IDEX,
    input  logic [4:0] rd_IDEX,
    input  logic [4:0] rs1_IFID,
    input  logic [4:0] rs2_IFID,
    input  logic       uses_rs1_IFID,
    input  logic       uses_rs2_IFID,
    input  logic       div_start_IDEX,
    input  logic       branch_taken_EX,
    output logic       stall_if,
    output logic       stall_id,
    output logic       stall_ex,
    output logic       bubble_ex,
    output logic       bubble_mem,
    output logic       flush_id,
    output logic       div_busy
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] perf_load_stalls,
    output logic [31:0] perf_div_stalls,
    output logic [31:0] perf_flushes
`endif
);

    localparam int CW = $clog2(DIV_LATENCY) + 1;
    localparam bit DIV_EN = (DIV_LATENCY > 1);
    // The start cycle is the first stall cycle, so DIV_WAIT needs
    // DIV_LATENCY-2 further stall cycles before reaching cnt==0 (release).
    localparam logic [CW-1:0] CNT_INIT = CW'(DIV_EN ? DIV_LATENCY - 2 : 0);

    typedef enum logic {
        RUN,
        DIV_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            load_use;
    logic            ev_load;

    assign load_use = MemRead_IDEX && (rd_IDEX != 5'd0) &&
                      ((uses_rs1_IFID && (rd_IDEX == rs1_IFID)) ||
                       (uses_rs2_IFID && (rd_IDEX == rs2_IFID)));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stall_if   = 1'b0;
        stall_id   = 1'b0;
        stall_ex   = 1'b0;
        bubble_ex  = 1'b0;
        bubble_mem = 1'b0;
        flush_id   = 1'b0;
        div_busy   = 1'b0;
        ev_load    = 1'b0;
        if (!rst) begin
            unique case (state_q)
                RUN: begin
                    // A divide in EX wins over everything: it cannot also be
                    // the taken branch, and it masks a stray load-use.
                    if (DIV_EN && div_start_IDEX) begin
                        stall_if   = 1'b1;
                        stall_id   = 1'b1;
                        stall_ex   = 1'b1;
                        bubble_mem = 1'b1;
                        div_busy   = 1'b1;
                        cnt_d      = CNT_INIT;
                        state_d    = DIV_WAIT;
                    end else if (branch_taken_EX) begin
                        // ID holds a wrong-path instruction, so its load-use
                        // dependency is irrelevant.
                        flush_id  = 1'b1;
                        bubble_ex = 1'b1;
                    end else if (load_use && !div_start_IDEX) begin
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        bubble_ex = 1'b1;
                        ev_load   = 1'b1;
                    end
                end
                DIV_WAIT: begin
                    if (cnt_q != '0) begin
                        stall_if   = 1'b1;
                        stall_id   = 1'b1;
                        stall_ex   = 1'b1;
                        bubble_mem = 1'b1;
                        div_busy   = 1'b1;
                        cnt_d      = cnt_q - CW'(1);
                    end else begin
                        // Release cycle: the divide result advances.
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_load_q, perf_load_d;
    logic [31:0] perf_div_q,  perf_div_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    // Saturating increments: a pinned counter stays at all-ones.
    always_comb begin
        perf_load_d  = perf_load_q;
        perf_div_d   = perf_div_q;
        perf_flush_d = perf_flush_q;
        if (ev_load && (perf_load_q != 32'hFFFF_FFFF))
            perf_load_d = perf_load_q + 32'd1;
        if (div_busy && (perf_div_q != 32'hFFFF_FFFF))
            perf_div_d = perf_div_q + 32'd1;
        if (flush_id && (perf_flush_q != 32'hFFFF_FFFF))
            perf_flush_d = perf_flush_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_load_q  <= '0;
            perf_div_q   <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_load_q  <= perf_load_d;
            perf_div_q   <= perf_div_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_load_stalls = perf_load_q;
    assign perf_div_stalls  = perf_div_q;
    assign perf_flushes     = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: directed scenarios followed by random
// stimulus, all checked against a cycle-count reference model. Two
// instances are exercised: DIV_LATENCY=4 and DIV_LATENCY=1.
module tb_hazard_stall_unit;

    localparam int L = 4;
    // {stall_if, stall_id, stall_ex, bubble_ex, bubble_mem, flush_id, div_busy}
    localparam logic [6:0] V_DIV = 7'b1110101;
    localparam logic [6:0] V_BR  = 7'b0001010;
    localparam logic [6:0] V_LU  = 7'b1101000;

    logic       clk = 1'b0;
    logic       rst;
    logic       mr, u1, u2, dv, br;
    logic [4:0] rd, rs1, rs2;

    logic a_if, a_id, a_ex, a_bex, a_bmem, a_fl, a_busy;
    logic b_if, b_id, b_ex, b_bex, b_bmem, b_fl, b_busy;
    logic [6:0] out4, out1;
    assign out4 = {a_if, a_id, a_ex, a_bex, a_bmem, a_fl, a_busy};
    assign out1 = {b_if, b_id, b_ex, b_bex, b_bmem, b_fl, b_busy};

`ifdef HAZARD_PERF_EN
    logic [31:0] a_pl, a_pd, a_pf, b_pl, b_pd, b_pf;
`endif

    hazard_stall_unit #(.DIV_LATENCY(L)) dut (
        .clk(clk), .rst(rst), .MemRead_IDEX(mr), .rd_IDEX(rd),
        .rs1_IFID(rs1), .rs2_IFID(rs2), .uses_rs1_IFID(u1), .uses_rs2_IFID(u2),
        .div_start_IDEX(dv), .branch_taken_EX(br),
        .stall_if(a_if), .stall_id(a_id), .stall_ex(a_ex), .bubble_ex(a_bex),
        .bubble_mem(a_bmem), .flush_id(a_fl), .div_busy(a_busy)
`ifdef HAZARD_PERF_EN
        , .perf_load_stalls(a_pl), .perf_div_stalls(a_pd), .perf_flushes(a_pf)
`endif
    );

    hazard_stall_unit #(.DIV_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .MemRead_IDEX(mr), .rd_IDEX(rd),
        .rs1_IFID(rs1), .rs2_IFID(rs2), .uses_rs1_IFID(u1), .uses_rs2_IFID(u2),
        .div_start_IDEX(dv), .branch_taken_EX(br),
        .stall_if(b_if), .stall_id(b_id), .stall_ex(b_ex), .bubble_ex(b_bex),
        .bubble_mem(b_bmem), .flush_id(b_fl), .div_busy(b_busy)
`ifdef HAZARD_PERF_EN
        , .perf_load_stalls(b_pl), .perf_div_stalls(b_pd), .perf_flushes(b_pf)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    // Cycles elapsed inside the current divide (0 = not dividing).
    int cyc4 = 0;
    int cyc1 = 0;
    longint pl = 0, pd = 0, pf = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: a divide stalls for cycles 0..ll-2 after it starts and
    // releases in cycle ll-1; otherwise divide > branch > load-use.
    task automatic model(input int ll, input int c, output logic [6:0] o, output int nc);
        bit luse;
        luse = mr && (rd != 0) && ((u1 && rd == rs1) || (u2 && rd == rs2));
        o  = '0;
        nc = 0;
        if (rst) return;
        if (c > 0 && c < ll - 1) begin
            o  = V_DIV;
            nc = c + 1;
        end else if (c > 0) begin
            nc = 0;
        end else if (dv && ll > 1) begin
            o  = V_DIV;
            nc = 1;
        end else if (br) begin
            o = V_BR;
        end else if (luse && !dv) begin
            o = V_LU;
        end
    endtask

    task automatic reset_model();
        cyc4 = 0; cyc1 = 0; pl = 0; pd = 0; pf = 0;
    endtask

    // Evaluate one cycle: compare, advance the model, move to next negedge.
    task automatic step(input string tag);
        logic [6:0] e4, e1;
        int n4, n1;
        #1;
        if (rst) reset_model();
        model(L, cyc4, e4, n4);
        model(1, cyc1, e1, n1);
        chk({tag, "/L4"}, 32'(out4), 32'(e4));
        chk({tag, "/L1"}, 32'(out1), 32'(e1));
`ifdef HAZARD_PERF_EN
        chk({tag, "/pl"}, a_pl, pl[31:0]);
        chk({tag, "/pd"}, a_pd, pd[31:0]);
        chk({tag, "/pf"}, a_pf, pf[31:0]);
        if (e4 == V_LU && pl < 64'hFFFF_FFFF) pl++;
        if (e4[0] && pd < 64'hFFFF_FFFF) pd++;
        if (e4[1] && pf < 64'hFFFF_FFFF) pf++;
`endif
        cyc4 = n4;
        cyc1 = n1;
        @(negedge clk);
    endtask

    task automatic drive(input logic m, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic x1, input logic x2,
                         input logic v, input logic b);
        mr = m; rd = d; rs1 = s1; rs2 = s2; u1 = x1; u2 = x2; dv = v; br = b;
    endtask

    task automatic expect_now(input string tag, input logic [6:0] v);
        #1;
        chk(tag, 32'(out4), 32'(v));
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        // Reset holds all outputs low even with a hazard presented.
        drive(1, 5, 5, 0, 1, 0, 1, 1);
        expect_now("rst_out", 7'b0);
        step("rst_hold");
        rst = 1'b0;

        // Load-use: exactly one cycle of stall.
        drive(1, 5, 5, 0, 1, 0, 0, 0);
        expect_now("lu", V_LU);
        step("lu");
        drive(0, 5, 5, 0, 1, 0, 0, 0);
        expect_now("lu_after", 7'b0);
        step("lu_after");

        // No false stalls.
        drive(1, 0, 0, 0, 1, 1, 0, 0);
        expect_now("rd_zero", 7'b0);
        step("rd_zero");
        drive(1, 5, 1, 5, 1, 0, 0, 0);
        expect_now("rs2_unused", 7'b0);
        step("rs2_unused");

        // Branch beats load-use.
        drive(1, 5, 5, 0, 1, 0, 0, 1);
        expect_now("br_prio", V_BR);
        step("br_prio");

        // Divide held high: stall cycles 0-2, release 3, new divide at 4.
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            expect_now($sformatf("div_c%0d", i), (i == 3) ? 7'b0 : V_DIV);
            chk("div_l1", 32'(out1), 32'd0);
            step($sformatf("div_c%0d", i));
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("div_drain");

        // Reset pulsed during the first DIV_WAIT cycle aborts the stall.
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        step("rd_c0");
        #2 rst = 1'b1;
        expect_now("rst_async", 7'b0);
        reset_model();
        @(negedge clk);
        step("rd_hold");
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_now($sformatf("rd_fresh%0d", i), (i == 3) ? 7'b0 : V_DIV);
            step("rd_fresh");
        end

`ifdef HAZARD_PERF_EN
        // 2 load-use, one 4-cycle divide, 1 flush -> 2, 3, 1.
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step("perf_rst");
        rst = 1'b0;
        drive(1, 7, 0, 7, 0, 1, 0, 0);
        step("perf_lu");
        step("perf_lu");
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step("perf_div");
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        step("perf_br");
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step("perf_idle");
        chk("perf_pl_2", a_pl, 32'd2);
        chk("perf_pd_3", a_pd, 32'd3);
        chk("perf_pf_1", a_pf, 32'd1);
        // Saturation: a pinned counter ignores further events.
        force dut.perf_flush_q = 32'hFFFF_FFFF;
        #1 release dut.perf_flush_q;
        pf = 64'hFFFF_FFFF;
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        step("perf_sat");
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step("perf_sat2");
        chk("perf_sat_hold", a_pf, 32'hFFFF_FFFF);
`endif

        // Random traffic with small register numbers to hit dependencies.
        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            mr  = $urandom_range(0, 1);
            rd  = 5'($urandom_range(0, 3));
            rs1 = 5'($urandom_range(0, 3));
            rs2 = 5'($urandom_range(0, 3));
            u1  = $urandom_range(0, 1);
            u2  = $urandom_range(0, 1);
            dv  = ($urandom_range(0, 7) == 0) || (cyc4 != 0 && $urandom_range(0, 1) == 1);
            br  = dv ? 1'b0 : ($urandom_range(0, 4) == 0);
            step("rand");
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
